// File: rtl/iec_drive_pkg.sv
// Shared types and constants for the IEC drive SD-channel sharing logic.
package iec_drive_pkg;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} arb_state_t;

    localparam int MAX_DRIVES = 4;
    localparam int SD_LBA_W   = 32;
    localparam int SD_BLK_W   = 6;
    localparam int IDX_W      = 2;

    function automatic int clamp_drives(input int d);
        if (d < 1)
            return 1;
        if (d > MAX_DRIVES)
            return MAX_DRIVES;
        return d;
    endfunction

endpackage

// File: rtl/iec_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping modulo NDR.
module iec_rr_pick
    import iec_drive_pkg::*;
#(
    parameter int NDR = 2
) (
    input  logic [NDR-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*NDR-1:0] rot;
    logic [NDR-1:0]   hit;
    logic [IDX_W-1:0] cand [NDR];

    // Doubling the vector lets a plain shift perform the modulo rotation.
    assign rot = {req, req} >> ptr;
    assign hit = rot[NDR-1:0];

    generate
        for (genvar gi = 0; gi < NDR; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(ptr) + gi) % NDR);
        end
    endgenerate

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NDR - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Round-robin sharing of the host SD sector channel between up to four IEC drives.
module iec_sd_arbiter
    import iec_drive_pkg::*;
#(
    parameter  int DRIVES = 2,
    parameter  int TMO_W  = 16,
    localparam int NDR    = clamp_drives(DRIVES),
    localparam int N      = NDR - 1
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [N:0]                drv_reset,
    input  logic [SD_LBA_W*NDR-1:0]   drv_lba,
    input  logic [SD_BLK_W*NDR-1:0]   drv_blk_cnt,
    input  logic [N:0]                drv_rd,
    input  logic [N:0]                drv_wr,
    output logic [N:0]                drv_ack,
    output logic [N:0]                drv_buff_wr,
    input  logic [8*NDR-1:0]          drv_buff_din,
    output logic [N:0]                drv_err,
    output logic [SD_LBA_W-1:0]       sd_lba,
    output logic [SD_BLK_W-1:0]       sd_blk_cnt,
    output logic                      sd_rd,
    output logic                      sd_wr,
    input  logic                      sd_ack,
    input  logic                      sd_buff_wr,
    output logic [7:0]                sd_buff_din,
    output logic                      busy
);

    arb_state_t          state_reg, state_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [IDX_W-1:0]    g_reg, g_next;
    logic                op_wr_reg, op_wr_next;
    logic                req_reg, req_next;
    logic                squelch_reg, squelch_next;
    logic [TMO_W-1:0]    tmo_reg, tmo_next, tmo_inc;
    logic [SD_LBA_W-1:0] lba_reg, lba_next;
    logic [SD_BLK_W-1:0] blk_reg, blk_next;
    logic [N:0]          err_reg, err_next;

    logic [N:0]          elig;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;

    // Per-drive views padded to MAX_DRIVES so a full-width index never overruns.
    logic [SD_LBA_W-1:0] lba_arr [MAX_DRIVES];
    logic [SD_BLK_W-1:0] blk_arr [MAX_DRIVES];
    logic [7:0]          din_arr [MAX_DRIVES];
    logic [MAX_DRIVES-1:0] wr_pad, rst_pad;

    generate
        for (genvar gi = 0; gi < MAX_DRIVES; gi++) begin : g_pad
            if (gi < NDR) begin : g_real
                assign lba_arr[gi] = drv_lba[gi*SD_LBA_W +: SD_LBA_W];
                assign blk_arr[gi] = drv_blk_cnt[gi*SD_BLK_W +: SD_BLK_W];
                assign din_arr[gi] = drv_buff_din[gi*8 +: 8];
                assign wr_pad[gi]  = drv_wr[gi];
                assign rst_pad[gi] = drv_reset[gi];
            end else begin : g_none
                assign lba_arr[gi] = '0;
                assign blk_arr[gi] = '0;
                assign din_arr[gi] = '0;
                assign wr_pad[gi]  = 1'b0;
                assign rst_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign elig = (drv_rd | drv_wr) & ~drv_reset;

    iec_rr_pick #(.NDR(NDR)) u_pick (
        .req   (elig),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign tmo_inc = tmo_reg + 1'b1;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        g_next       = g_reg;
        op_wr_next   = op_wr_reg;
        req_next     = req_reg;
        squelch_next = squelch_reg;
        tmo_next     = tmo_reg;
        lba_next     = lba_reg;
        blk_next     = blk_reg;
        err_next     = '0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    g_next       = pick_idx;
                    lba_next     = lba_arr[pick_idx];
                    blk_next     = blk_arr[pick_idx];
                    op_wr_next   = wr_pad[pick_idx];
                    req_next     = 1'b1;
                    squelch_next = 1'b0;
                    tmo_next     = '0;
                    state_next   = REQ;
                end
            end
            REQ: begin
                tmo_next = tmo_inc;
                if (sd_ack) begin
                    // Host has committed; a drive reset now only mutes forwarding.
                    req_next     = 1'b0;
                    squelch_next = rst_pad[g_reg];
                    state_next   = XFER;
                end else if (rst_pad[g_reg]) begin
                    req_next   = 1'b0;
                    state_next = GAP;
                end else if (&tmo_inc) begin
                    req_next = 1'b0;
                    for (int i = 0; i < NDR; i++) begin
                        if (g_reg == IDX_W'(i))
                            err_next[i] = 1'b1;
                    end
                    state_next = GAP;
                end
            end
            XFER: begin
                squelch_next = squelch_reg | rst_pad[g_reg];
                if (!sd_ack)
                    state_next = GAP;
            end
            GAP: begin
                ptr_next   = IDX_W'((int'(g_reg) + 1) % NDR);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            g_reg       <= '0;
            op_wr_reg   <= 1'b0;
            req_reg     <= 1'b0;
            squelch_reg <= 1'b0;
            tmo_reg     <= '0;
            lba_reg     <= '0;
            blk_reg     <= '0;
            err_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            g_reg       <= g_next;
            op_wr_reg   <= op_wr_next;
            req_reg     <= req_next;
            squelch_reg <= squelch_next;
            tmo_reg     <= tmo_next;
            lba_reg     <= lba_next;
            blk_reg     <= blk_next;
            err_reg     <= err_next;
        end
    end

    assign sd_rd      = req_reg & ~op_wr_reg;
    assign sd_wr      = req_reg & op_wr_reg;
    assign sd_lba     = lba_reg;
    assign sd_blk_cnt = blk_reg;
    assign drv_err    = err_reg;
    assign busy       = (state_reg != IDLE);

    always_comb begin
        drv_ack     = '0;
        drv_buff_wr = '0;
        sd_buff_din = '0;
        if (state_reg == XFER) begin
            sd_buff_din = din_arr[g_reg];
            if (!squelch_reg && !rst_pad[g_reg]) begin
                for (int i = 0; i < NDR; i++) begin
                    if (g_reg == IDX_W'(i)) begin
                        drv_ack[i]     = sd_ack;
                        drv_buff_wr[i] = sd_buff_wr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed scoreboard bench for iec_sd_arbiter with two drives and a 4-bit ack timeout.
module tb_iec_sd_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [1:0]  drv_reset, drv_rd, drv_wr, drv_ack, drv_buff_wr, drv_err;
    logic [63:0] drv_lba;
    logic [11:0] drv_blk_cnt;
    logic [15:0] drv_buff_din;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
    logic [7:0]  sd_buff_din;

    typedef struct {
        logic [31:0] lba;
        logic [5:0]  blk;
        logic        wr;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  err_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        req_prev = 1'b0;

    always #5 clk_sys = ~clk_sys;

    iec_sd_arbiter #(.DRIVES(2), .TMO_W(4)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .drv_reset    (drv_reset),
        .drv_lba      (drv_lba),
        .drv_blk_cnt  (drv_blk_cnt),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_wr  (drv_buff_wr),
        .drv_buff_din (drv_buff_din),
        .drv_err      (drv_err),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wait_req();
        int w = 0;
        while (!(sd_rd | sd_wr) && w < 40) begin
            tick();
            w++;
        end
        if (w >= 40) begin
            checks++;
            errors++;
            $display("FAIL host_wait: got no request expected sd_rd/sd_wr");
        end
    endtask

    // Host side of one transfer; returns on the negedge where sd_ack is dropped.
    task automatic host_xfer(input int nstb, input bit drop);
        wait_req();
        if (drop) begin
            drv_rd = '0;
            drv_wr = '0;
        end
        sd_ack = 1'b1;
        tick();
        repeat (nstb) begin
            sd_buff_wr = 1'b1;
            tick();
            sd_buff_wr = 1'b0;
            tick();
        end
        sd_ack = 1'b0;
    endtask

    // Monitor: pops an expectation each time a host request or error pulse appears.
    always @(negedge clk_sys) begin
        exp_t e;
        logic req_now;
        req_now = sd_rd | sd_wr;
        if (req_now && !req_prev) begin
            $display("req lba=%h blk=%0d rd=%0b wr=%0b", sd_lba, sd_blk_cnt, sd_rd, sd_wr);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got lba %h expected none", sd_lba);
            end else begin
                e = exp_q.pop_front();
                chk("req_lba", sd_lba, e.lba);
                chk("req_blk", 32'(sd_blk_cnt), 32'(e.blk));
                chk("req_wr", 32'(sd_wr), 32'(e.wr));
                chk("req_rd", 32'(sd_rd), 32'(!e.wr));
            end
        end
        req_prev = req_now;
        if (drv_err != 2'b00) begin
            $display("err drv_err=%b", drv_err);
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_err: got %b expected none", drv_err);
            end else begin
                chk("err_val", 32'(drv_err), 32'(err_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt1, hi, errs;
        reset_n = 1'b0; drv_reset = '0; drv_rd = '0; drv_wr = '0;
        drv_lba = '0; drv_blk_cnt = '0; drv_buff_din = '0;
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        repeat (3) tick();
        chk("rst_sd_rd", 32'(sd_rd), 0);
        chk("rst_sd_wr", 32'(sd_wr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_blk", 32'(sd_blk_cnt), 0);
        chk("rst_err", 32'(drv_err), 0);
        chk("rst_din", 32'(sd_buff_din), 0);
        reset_n = 1'b1;
        tick();

        // Single read from drive 0 with 512 strobes.
        drv_lba[31:0] = 32'h123;
        drv_rd[0] = 1'b1;
        exp_q.push_back('{lba: 32'h123, blk: 6'd0, wr: 1'b0});
        tick();
        chk("t1_sd_rd", 32'(sd_rd), 1);
        chk("t1_lba", sd_lba, 32'h123);
        drv_rd[0] = 1'b0;
        tick();
        sd_ack = 1'b1;
        tick();
        chk("t1_rd_drop", 32'(sd_rd), 0);
        chk("t1_busy", 32'(busy), 1);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_wr = 1'b1;
            #1;
            if (drv_buff_wr[0]) cnt0++;
            if (drv_buff_wr[1]) cnt1++;
            if (i == 0) chk("t1_drv_ack", 32'(drv_ack), 32'h1);
            tick();
            sd_buff_wr = 1'b0;
            tick();
        end
        chk("t1_strobes0", 32'(cnt0), 512);
        chk("t1_strobes1", 32'(cnt1), 0);
        sd_ack = 1'b0;
        tick();
        chk("t1_gap_busy", 32'(busy), 1);
        tick();
        chk("t1_idle_busy", 32'(busy), 0);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;

        // Contention: grant order 0,1,0,1 with one GAP plus one IDLE between requests.
        drv_lba = {32'h2000, 32'h1000};
        drv_blk_cnt = {6'd7, 6'd3};
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back('{lba: 32'h1000, blk: 6'd3, wr: 1'b0});
            exp_q.push_back('{lba: 32'h2000, blk: 6'd7, wr: 1'b0});
        end
        drv_rd = 2'b11;
        for (int t = 0; t < 4; t++) begin
            host_xfer(2, t == 3);
            tick();
            chk("t2_gap_busy", 32'(busy), 1);
            chk("t2_gap_rd", 32'(sd_rd), 0);
            tick();
            chk("t2_idle_busy", 32'(busy), 0);
            if (t < 3) begin
                tick();
                chk("t2_next_req", 32'(sd_rd), 1);
            end
        end

        // Write priority and data mux on drive 1.
        drv_lba[63:32] = 32'h777;
        drv_buff_din = {8'hA5, 8'h5A};
        tick();
        chk("t3_din_idle", 32'(sd_buff_din), 0);
        exp_q.push_back('{lba: 32'h777, blk: 6'd7, wr: 1'b1});
        drv_rd[1] = 1'b1;
        drv_wr[1] = 1'b1;
        wait_req();
        drv_rd = '0; drv_wr = '0;
        sd_ack = 1'b1;
        tick();
        chk("t3_din_xfer", 32'(sd_buff_din), 32'hA5);
        sd_ack = 1'b0;
        tick();
        tick();
        chk("t3_din_after", 32'(sd_buff_din), 0);

        // Timeout on drive 0, then drive 1 is served.
        drv_lba = {32'hBBB, 32'hAAA};
        exp_q.push_back('{lba: 32'hAAA, blk: 6'd3, wr: 1'b0});
        exp_q.push_back('{lba: 32'hBBB, blk: 6'd7, wr: 1'b0});
        err_q.push_back(2'b01);
        drv_rd = 2'b11;
        wait_req();
        drv_rd[0] = 1'b0;
        hi = 0;
        while (sd_rd && hi < 40) begin
            hi++;
            tick();
        end
        chk("t4_timeout_len", 32'(hi), 15);
        chk("t4_err_pulse", 32'(drv_err), 32'h1);
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (drv_err[0]) errs++;
            tick();
        end
        chk("t4_err_count", 32'(errs), 1);
        host_xfer(1, 1);
        tick();
        tick();

        // Abort of drive 1 during REQ: no error pulse.
        drv_lba[63:32] = 32'hC01;
        exp_q.push_back('{lba: 32'hC01, blk: 6'd7, wr: 1'b0});
        drv_rd[1] = 1'b1;
        wait_req();
        drv_reset[1] = 1'b1;
        drv_rd[1] = 1'b0;
        tick();
        chk("t5_abort_rd", 32'(sd_rd), 0);
        chk("t5_abort_busy", 32'(busy), 1);
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (drv_err != 2'b00) errs++;
            tick();
        end
        chk("t5_no_err", 32'(errs), 0);
        drv_reset = '0;

        // Drive 0 reset mid-transfer: forwarding muted, arbiter waits for sd_ack to fall.
        drv_lba[31:0] = 32'hD00;
        exp_q.push_back('{lba: 32'hD00, blk: 6'd3, wr: 1'b0});
        drv_rd[0] = 1'b1;
        wait_req();
        drv_rd[0] = 1'b0;
        sd_ack = 1'b1;
        tick();
        sd_buff_wr = 1'b1;
        #1;
        chk("t5_ack_fwd", 32'(drv_ack), 32'h1);
        chk("t5_bwr_fwd", 32'(drv_buff_wr), 32'h1);
        drv_reset[0] = 1'b1;
        #1;
        chk("t5_ack_mute", 32'(drv_ack), 0);
        chk("t5_bwr_mute", 32'(drv_buff_wr), 0);
        tick();
        sd_buff_wr = 1'b0;
        tick();
        tick();
        chk("t5_hold_busy", 32'(busy), 1);
        chk("t5_hold_rd", 32'(sd_rd), 0);
        drv_reset = '0;
        sd_ack = 1'b0;
        tick();
        chk("t5_gap_busy", 32'(busy), 1);
        tick();
        chk("t5_idle_busy", 32'(busy), 0);

        // Synchronous reset during XFER; ptr must return to drive 0.
        drv_lba[63:32] = 32'hE00;
        exp_q.push_back('{lba: 32'hE00, blk: 6'd7, wr: 1'b0});
        drv_rd[1] = 1'b1;
        wait_req();
        drv_rd[1] = 1'b0;
        sd_ack = 1'b1;
        tick();
        chk("t6_xfer_busy", 32'(busy), 1);
        reset_n = 1'b0;
        tick();
        chk("t6_rst_rd", 32'(sd_rd), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_lba", sd_lba, 0);
        chk("t6_rst_ack", 32'(drv_ack), 0);
        reset_n = 1'b1;
        sd_ack = 1'b0;
        drv_lba = {32'hF01, 32'hF00};
        exp_q.push_back('{lba: 32'hF00, blk: 6'd3, wr: 1'b0});
        exp_q.push_back('{lba: 32'hF01, blk: 6'd7, wr: 1'b0});
        drv_rd = 2'b11;
        host_xfer(1, 0);
        host_xfer(1, 1);

        repeat (6) tick();
        chk("exp_q_empty", 32'(exp_q.size()), 0);
        chk("err_q_empty", 32'(err_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
